// File: rtl/ask_packet_rcv.sv
`default_nettype none
// ============================================================================
// Module   : ask_packet_rcv
// Purpose  : Oversampled ASK receiver: preamble correlation, symbol timing,
//            sync word search and fixed-length payload word delivery.
// Revision : 1.0 - initial release
// ============================================================================
module ask_packet_rcv #(
    parameter int                          OVERSAMPLE     = 4,
    parameter int                          PREAMBLE_WIDTH = 32,
    parameter logic [PREAMBLE_WIDTH-1:0]   PREAMBLE       = 32'hF0F0F0F0,
    parameter int                          PREAMBLE_ERRS  = 1,
    parameter int                          SYNCWORD_WIDTH = 8,
    parameter logic [SYNCWORD_WIDTH-1:0]   SYNCWORD       = 8'hE5,
    parameter int                          SYNCWORD_ERRS  = 0,
    parameter int                          DATA_WIDTH     = 8,
    parameter int                          PAYLOAD_LEN    = 4,
    parameter int                          SYNC_TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serialin,
    input  logic                  restart,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  sync_lost,
    output logic                  locked,
    output logic                  synced,
    output logic                  sym_stb
);

    localparam int PMW = $clog2(PREAMBLE_WIDTH) + 1;
    localparam int SMW = $clog2(SYNCWORD_WIDTH) + 1;
    localparam int PHW = $clog2(OVERSAMPLE);
    localparam int SCW = $clog2(SYNC_TIMEOUT + 1);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int WCW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

    localparam logic [PMW-1:0] PRE_THRESH  = PMW'(PREAMBLE_WIDTH - PREAMBLE_ERRS);
    localparam logic [SMW-1:0] SYNC_THRESH = SMW'(SYNCWORD_WIDTH - SYNCWORD_ERRS);
    localparam logic [PHW-1:0] PHASE_STB   = PHW'(OVERSAMPLE / 2 - 1);
    localparam logic [PHW-1:0] PHASE_LAST  = PHW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] SYM_MIN     = SCW'(SYNCWORD_WIDTH);
    localparam logic [SCW-1:0] SYM_TIMEOUT = SCW'(SYNC_TIMEOUT);
    localparam logic [BCW-1:0] BIT_LAST    = BCW'(DATA_WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST   = WCW'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {
        ST_HUNT        = 2'd0,
        ST_SYNC_SEARCH = 2'd1,
        ST_PAYLOAD     = 2'd2
    } state_t;

    function automatic logic [PMW-1:0] pre_score(input logic [PREAMBLE_WIDTH-1:0] v);
        logic [PMW-1:0] n;
        n = '0;
        for (int i = 0; i < PREAMBLE_WIDTH; i++) begin
            n = n + PMW'(v[i] ~^ PREAMBLE[i]);
        end
        return n;
    endfunction

    function automatic logic [SMW-1:0] sync_score(input logic [SYNCWORD_WIDTH-1:0] v);
        logic [SMW-1:0] n;
        n = '0;
        for (int i = 0; i < SYNCWORD_WIDTH; i++) begin
            n = n + SMW'(v[i] ~^ SYNCWORD[i]);
        end
        return n;
    endfunction

    state_t                      state_q,       state_d;
    logic                        sin_q,         sin_d;
    logic [PREAMBLE_WIDTH-1:0]   pre_shreg_q,   pre_shreg_d;
    logic [PHW-1:0]              phase_q,       phase_d;
    logic [SYNCWORD_WIDTH-1:0]   sync_shreg_q,  sync_shreg_d;
    logic [SCW-1:0]              sym_cnt_q,     sym_cnt_d;
    logic [DATA_WIDTH-1:0]       word_q,        word_d;
    logic [BCW-1:0]              bit_cnt_q,     bit_cnt_d;
    logic [WCW-1:0]              word_cnt_q,    word_cnt_d;
    logic [DATA_WIDTH-1:0]       data_q,        data_d;
    logic                        data_valid_q,  data_valid_d;
    logic                        frame_start_q, frame_start_d;
    logic                        frame_end_q,   frame_end_d;
    logic                        sync_lost_q,   sync_lost_d;

    logic [PMW-1:0]              pre_match;
    logic                        pre_hit;
    logic                        stb;
    logic [SYNCWORD_WIDTH-1:0]   sync_shifted;
    logic [SMW-1:0]              sync_match;
    logic [SCW-1:0]              sym_cnt_inc;
    logic                        sync_ok;
    logic [DATA_WIDTH-1:0]       word_shifted;

    always_comb begin
        pre_match    = pre_score(pre_shreg_q);
        pre_hit      = (pre_match >= PRE_THRESH);
        stb          = (state_q != ST_HUNT) && (phase_q == PHASE_STB);
        sync_shifted = {sync_shreg_q[SYNCWORD_WIDTH-2:0], sin_q};
        sync_match   = sync_score(sync_shifted);
        sym_cnt_inc  = sym_cnt_q + SCW'(1);
        sync_ok      = (sym_cnt_inc >= SYM_MIN) && (sync_match >= SYNC_THRESH);
        word_shifted = {word_q[DATA_WIDTH-2:0], sin_q};
    end

    always_comb begin
        sin_d         = serialin;
        pre_shreg_d   = {pre_shreg_q[PREAMBLE_WIDTH-2:0], sin_q};
        phase_d       = (phase_q == PHASE_LAST) ? '0 : phase_q + PHW'(1);
        state_d       = state_q;
        sync_shreg_d  = sync_shreg_q;
        sym_cnt_d     = sym_cnt_q;
        word_d        = word_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        sync_lost_d   = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (pre_hit) begin
                    state_d      = ST_SYNC_SEARCH;
                    phase_d      = '0;
                    sync_shreg_d = '0;
                    sym_cnt_d    = '0;
                end
            end
            ST_SYNC_SEARCH: begin
                if (pre_hit) begin
                    phase_d = '0;
                end
                if (stb) begin
                    sync_shreg_d = sync_shifted;
                    sym_cnt_d    = sym_cnt_inc;
                    // A match on the timeout symbol still wins.
                    if (sync_ok) begin
                        state_d       = ST_PAYLOAD;
                        frame_start_d = 1'b1;
                        bit_cnt_d     = '0;
                        word_cnt_d    = '0;
                    end else if (sym_cnt_inc == SYM_TIMEOUT) begin
                        state_d     = ST_HUNT;
                        sync_lost_d = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (stb) begin
                    word_d = word_shifted;
                    if (bit_cnt_q == BIT_LAST) begin
                        data_d       = word_shifted;
                        data_valid_d = 1'b1;
                        bit_cnt_d    = '0;
                        word_cnt_d   = word_cnt_q + WCW'(1);
                        if (word_cnt_q == WORD_LAST) begin
                            frame_end_d = 1'b1;
                            word_cnt_d  = '0;
                            state_d     = ST_HUNT;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // The correlator history survives a restart so a preamble in flight is not lost.
        if (restart) begin
            state_d       = ST_HUNT;
            phase_d       = '0;
            sym_cnt_d     = '0;
            bit_cnt_d     = '0;
            word_cnt_d    = '0;
            data_d        = data_q;
            data_valid_d  = 1'b0;
            frame_start_d = 1'b0;
            frame_end_d   = 1'b0;
            sync_lost_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_HUNT;
            sin_q         <= 1'b0;
            pre_shreg_q   <= '0;
            phase_q       <= '0;
            sync_shreg_q  <= '0;
            sym_cnt_q     <= '0;
            word_q        <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            sync_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sin_q         <= sin_d;
            pre_shreg_q   <= pre_shreg_d;
            phase_q       <= phase_d;
            sync_shreg_q  <= sync_shreg_d;
            sym_cnt_q     <= sym_cnt_d;
            word_q        <= word_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            sync_lost_q   <= sync_lost_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign sync_lost   = sync_lost_q;
    assign locked      = (state_q != ST_HUNT);
    assign synced      = (state_q == ST_PAYLOAD);
    assign sym_stb     = stb;

endmodule
`default_nettype wire

// File: tb/tb_ask_packet_rcv.sv
`default_nettype none
// Bench for ask_packet_rcv: framed ASK sample streams with a queue of expected
// strobe events and a per-cycle expectation of sym_stb/locked/synced.
module tb_ask_packet_rcv;

    localparam int          OS   = 4;
    localparam logic [31:0] PRE  = 32'hF0F0F0F0;
    localparam logic [7:0]  SW   = 8'hE5;
    localparam int          PERR = 1;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       serialin = 1'b0;
    logic       restart  = 1'b0;
    logic [7:0] data;
    logic       data_valid, frame_start, frame_end, sync_lost, locked, synced, sym_stb;

    ask_packet_rcv #(
        .OVERSAMPLE(OS), .PREAMBLE_WIDTH(32), .PREAMBLE(PRE), .PREAMBLE_ERRS(PERR),
        .SYNCWORD_WIDTH(8), .SYNCWORD(SW), .SYNCWORD_ERRS(0), .DATA_WIDTH(8),
        .PAYLOAD_LEN(4), .SYNC_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .serialin(serialin), .restart(restart),
        .data(data), .data_valid(data_valid), .frame_start(frame_start),
        .frame_end(frame_end), .sync_lost(sync_lost), .locked(locked),
        .synced(synced), .sym_stb(sym_stb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // kind: 0 frame_start, 1 data word, 2 sync_lost
    typedef struct {
        int         kind;
        logic [7:0] d;
        bit         last;
        int         at;
    } ev_t;
    ev_t exp_q[$];
    bit  mon_en = 1'b0;

    task automatic chk_ev(input int kind, input logic [7:0] d, input bit last);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected got kind=%0d data=%02h last=%0d cyc=%0d, required none",
                     kind, d, last, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.d != d || e.last != last || e.at != cyc) begin
                failures++;
                $display("FAIL event got kind=%0d data=%02h last=%0d cyc=%0d, required kind=%0d data=%02h last=%0d cyc=%0d",
                         kind, d, last, cyc, e.kind, e.d, e.last, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_start) chk_ev(0, 8'h00, 1'b0);
            if (data_valid)  chk_ev(1, data, frame_end);
            if (sync_lost)   chk_ev(2, 8'h00, 1'b0);
            if (frame_end && !data_valid) begin
                checks++;
                failures++;
                $display("FAIL frame_end_alone got frame_end=1 data_valid=0 cyc=%0d, required data_valid=1", cyc);
            end
        end
    end

    function automatic bit has_pre(input logic [7:0] p [4]);
        bit         s[$];
        logic [7:0] sw;
        logic [7:0] pat;
        bit         m;
        sw  = SW;
        pat = 8'hAA;
        for (int i = 0; i < 8; i++) s.push_back(sw[7-i]);
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 8; i++) s.push_back(p[w][7-i]);
        for (int i = 0; i < 8; i++) s.push_back(1'b0);
        for (int st = 0; st + 8 <= s.size(); st++) begin
            m = 1'b1;
            for (int j = 0; j < 8; j++) if (s[st+j] != pat[7-j]) m = 1'b0;
            if (m) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic rand_pay(output logic [7:0] p [4]);
        do begin
            for (int w = 0; w < 4; w++) p[w] = 8'($urandom_range(0, 255));
        end while (has_pre(p));
    endtask

    // rst_sym / rstn_sym: post-preamble symbol index at which restart or reset
    // is applied for one cycle (-1 = never).
    task automatic send_frame(input logic [7:0] pay [4], input int offset, input int nflip,
                              input bit tmo, input int rst_sym, input int rstn_sym);
        bit         smp[$];
        bit         syms[$];
        logic [31:0] pre;
        logic [7:0]  sw;
        bit          b, hit, e_stb, e_lock, e_sync, is_rstn;
        int          base, k0, nsym, cut, flip_a, flip_b, fs_at, end_at, at;
        int          lock_lo, lock_hi, c, rel;
        pre = PRE;
        sw  = SW;
        for (int i = 0; i < 16 + offset; i++) smp.push_back(1'b0);
        flip_a = int'($urandom_range(0, 31));
        flip_b = (flip_a + 1 + int'($urandom_range(0, 30))) % 32;
        for (int i = 0; i < 32; i++) begin
            b = pre[31-i];
            if ((nflip >= 1 && i == flip_a) || (nflip >= 2 && i == flip_b)) b = ~b;
            smp.push_back(b);
        end
        base = smp.size();
        if (tmo) begin
            for (int i = 0; i < 16; i++) syms.push_back(1'b0);
        end else begin
            for (int i = 0; i < 8; i++) syms.push_back(sw[7-i]);
            for (int w = 0; w < 4; w++)
                for (int i = 0; i < 8; i++) syms.push_back(pay[w][7-i]);
        end
        nsym = syms.size();
        foreach (syms[s]) for (int j = 0; j < OS; j++) smp.push_back(syms[s]);
        for (int i = 0; i < 16; i++) smp.push_back(1'b0);

        k0  = cyc + 1;
        hit = (nflip <= PERR);
        cut = 32'h7fffffff;
        if (rst_sym >= 0)  cut = k0 + base + OS * rst_sym;
        if (rstn_sym >= 0) cut = k0 + base + OS * rstn_sym;

        fs_at  = k0 + base + OS * 7 + 4;
        end_at = k0 + base + OS * (tmo ? 15 : 39) + 4;
        if (hit) begin
            if (tmo) begin
                exp_q.push_back('{2, 8'h00, 1'b0, end_at});
            end else begin
                if (fs_at < cut) exp_q.push_back('{0, 8'h00, 1'b0, fs_at});
                for (int w = 0; w < 4; w++) begin
                    at = k0 + base + OS * (8 + 8 * w + 7) + 4;
                    if (at < cut) exp_q.push_back('{1, pay[w], (w == 3), at});
                end
            end
            lock_lo = k0 + base + 2;
            lock_hi = end_at - 1;
            if (rst_sym >= 0 && cut < lock_hi)      lock_hi = cut;
            if (rstn_sym >= 0 && cut - 1 < lock_hi) lock_hi = cut - 1;
        end else begin
            lock_lo = 1;
            lock_hi = 0;
        end

        for (int i = 0; i < smp.size(); i++) begin
            @(posedge clk);
            #1;
            is_rstn  = (rstn_sym >= 0 && i == base + OS * rstn_sym);
            serialin = smp[i];
            restart  = (rst_sym >= 0 && i == base + OS * rst_sym);
            reset    = !is_rstn;
            #1;
            c      = cyc;
            rel    = c - (k0 + base + 3);
            e_lock = (c >= lock_lo) && (c <= lock_hi);
            e_sync = hit && !tmo && (c >= fs_at) && (c <= lock_hi);
            e_stb  = hit && (rel >= 0) && (rel % OS == 0) && (rel / OS < nsym) && (c <= lock_hi);
            checks++;
            if ({sym_stb, locked, synced} !== {e_stb, e_lock, e_sync}) begin
                failures++;
                $display("FAIL status cyc=%0d got stb/locked/synced=%b%b%b, required %b%b%b",
                         c, sym_stb, locked, synced, e_stb, e_lock, e_sync);
            end
            if (is_rstn) begin
                checks++;
                if ({data, data_valid, frame_start, frame_end, sync_lost} !== 12'h000) begin
                    failures++;
                    $display("FAIL reset_outputs cyc=%0d got data=%02h strobes=%b%b%b%b, required all 0",
                             c, data, data_valid, frame_start, frame_end, sync_lost);
                end
            end
        end
        restart = 1'b0;
        reset   = 1'b1;
    endtask

    initial begin
        logic [7:0] p [4];
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({data, data_valid, frame_start, frame_end, sync_lost, locked, synced, sym_stb} !== 15'h0) begin
            failures++;
            $display("FAIL reset_state got data=%02h dv=%b fs=%b fe=%b sl=%b lk=%b sy=%b stb=%b, required all 0",
                     data, data_valid, frame_start, frame_end, sync_lost, locked, synced, sym_stb);
        end
        reset  = 1'b1;
        mon_en = 1'b1;

        p = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        send_frame(p, 0, 0, 1'b0, -1, -1);

        rand_pay(p); send_frame(p, 0, 1, 1'b0, -1, -1);
        rand_pay(p); send_frame(p, 0, 2, 1'b0, -1, -1);
        rand_pay(p); send_frame(p, 0, 0, 1'b0, -1, -1);

        send_frame(p, 0, 0, 1'b1, -1, -1);

        for (int off = 1; off <= 3; off++) begin
            rand_pay(p);
            send_frame(p, off, 0, 1'b0, -1, -1);
        end

        rand_pay(p); send_frame(p, 1, 0, 1'b0, 19, -1);
        rand_pay(p); send_frame(p, 0, 0, 1'b0, -1, -1);

        rand_pay(p); send_frame(p, 2, 0, 1'b0, -1, 28);
        rand_pay(p); send_frame(p, 0, 0, 1'b0, -1, -1);

        for (int k = 0; k < 4; k++) begin
            rand_pay(p);
            send_frame(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'b0, -1, -1);
        end

        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL events_missing got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ask_packet_rcv.md
Name: ask_packet_rcv

Overview:
Single-clock successor to the ASK symbol synchroniser and byte receiver. It does the following:
- takes oversampled serial ASK data;
- finds the preamble at sample rate with an error-tolerant correlator;
- recovers symbol timing with a phase counter realigned on preamble hits;
- searches for the sync word with tolerance and a timeout;
- then delivers a fixed-length payload as DATA_WIDTH-bit words with valid and frame strobes.

There are no derived clocks: all logic runs on clk with enables, feeding the downstream packet buffer.

Parameters:
- OVERSAMPLE, 4, samples per symbol; even, >=2.
- PREAMBLE_WIDTH, 32, preamble correlator length in samples.
- PREAMBLE, 32'hF0F0F0F0, sample-rate preamble template; MSB is the oldest sample.
- PREAMBLE_ERRS, 1, max mismatched samples still counted as a preamble hit.
- SYNCWORD_WIDTH, 8, sync word length in symbols.
- SYNCWORD, 8'hE5, sync word template; MSB first.
- SYNCWORD_ERRS, 0, max mismatched symbols for a sync match.
- DATA_WIDTH, 8, bits per output word.
- PAYLOAD_LEN, 4, words per frame; >=1.
- SYNC_TIMEOUT, 16, symbols allowed in SYNC_SEARCH before abandoning; must be >= SYNCWORD_WIDTH.

Ports:
- clk  in  1  sample clock.
- reset  in  1  asynchronous, active-low reset.
- serialin  in  1  raw demodulated ASK bit.
- restart  in  1  synchronous abort to HUNT.
- data  out  DATA_WIDTH  last completed payload word.
- data_valid  out  1  one-cycle strobe qualifying data.
- frame_start  out  1  one-cycle pulse on sync word match.
- frame_end  out  1  one-cycle pulse, coincident with the last data_valid of a frame.
- sync_lost  out  1  one-cycle pulse on SYNC_SEARCH timeout.
- locked  out  1  high when state != HUNT.
- synced  out  1  high when state == PAYLOAD.
- sym_stb  out  1  symbol sampling strobe (debug).

Behaviour:

Reset and input path
- Reset low: state=HUNT; all shift registers, counters and outputs are 0.
- sin_q registers serialin every clk; it is the only source of sampled data.

Preamble correlator
- pre_shreg shifts in sin_q every clk, in all states.
- match = count of bits where pre_shreg equals PREAMBLE.
- pre_hit is combinational: match >= PREAMBLE_WIDTH - PREAMBLE_ERRS.
- The counter has width clog2(PREAMBLE_WIDTH)+1 and must not overflow.

Symbol timing
- phase counts 0..OVERSAMPLE-1 and wraps.
- On a clk edge with pre_hit in HUNT or SYNC_SEARCH, phase <= 0; otherwise it increments.
- sym_stb = (state != HUNT) && (phase == OVERSAMPLE/2 - 1).
- On each sym_stb edge the symbol bit is sin_q.

State machine
- HUNT -> SYNC_SEARCH on the edge where pre_hit=1. On that edge: sync_shreg <= 0, sym_cnt <= 0.
- SYNC_SEARCH, on each sym_stb:
  - shift the bit into sync_shreg and increment sym_cnt.
  - Sync match requires sym_cnt >= SYNCWORD_WIDTH after the shift, and symbol matches >= SYNCWORD_WIDTH - SYNCWORD_ERRS.
  - On match: next state PAYLOAD, frame_start pulses the following cycle, bit_cnt <= 0, word_cnt <= 0.
  - Otherwise, if sym_cnt reaches SYNC_TIMEOUT: next state HUNT and sync_lost pulses.
  - If a match and the timeout occur on the same symbol, the match wins.
- SYNC_SEARCH with pre_hit realigns phase only; sync_shreg and sym_cnt are untouched.
- PAYLOAD:
  - pre_hit is ignored.
  - Each sym_stb shifts the bit MSB-first into the word register.
  - When bit_cnt reaches DATA_WIDTH-1: on the next edge data <= completed word and data_valid=1 for one cycle; bit_cnt <= 0; word_cnt increments.
  - On the word where word_cnt == PAYLOAD_LEN-1: frame_end=1 together with data_valid, and the state returns to HUNT on that same edge.
- data holds its value between strobes; data_valid, frame_start, frame_end and sync_lost are each high for exactly one clk.

restart
- restart=1 forces state HUNT on the next edge and clears phase and all counters.
- It has priority over every transition and suppresses any strobe that would be produced on that edge.
- pre_shreg is not cleared.

Reset mid-frame
- Immediate return to reset values; no partial word is emitted.

Latency
- Last payload bit sampled at a sym_stb edge -> data_valid on the following cycle.

Test Plan:
1. Clean frame, defaults: 32 samples F0F0F0F0, then sync word E5, then A5 3C 00 FF, each symbol held 4 samples -> frame_start once; data_valid x4 with data=A5,3C,00,FF; frame_end with the 4th word; locked falls afterwards.
2. Corrupted preamble: one sample flipped (PREAMBLE_ERRS=1) -> frame still received. Two samples flipped -> no lock until the next clean preamble.
3. Timeout: clean preamble, then 16 symbols of 0x00 -> sync_lost pulses exactly once after the 16th sym_stb; locked=0; no frame_start.
4. Phase tracking: preamble start offset by 1, 2 and 3 samples relative to the reset phase -> sym_stb lands 2 samples after each symbol edge; payload bytes are correct in all cases.
5. restart asserted for one cycle during the 2nd payload word -> no further data_valid; state HUNT. A following clean frame is received intact.
6. reset low for 1 cycle mid-payload -> all outputs 0 immediately; sym_stb stays low until the next preamble hit.
